// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// Holds the FSM state codes and the packed result-flag record.
// Imported by the top; the bit cell is self-contained.
package serial_magnitude_comparator_pkg;

  // FSM state codes
  localparam logic [1:0] CMP_IDLE    = 2'd0;
  localparam logic [1:0] CMP_COMPARE = 2'd1;
  localparam logic [1:0] CMP_DONE    = 2'd2;

  // Result flags, ordered {lt, gt, eq}
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cmp_flags_t;

  // All flags low: seen only after reset or while a compare is running
  localparam cmp_flags_t RES_NONE = 3'b000;

endpackage

// File: rtl/serial_magnitude_comparator_bit_cell.sv
// Single-bit compare cell: flags the first differing bit of a serial scan.
// Latency: combinational.
// Backpressure: none; the caller decides when its outputs are sampled.
module serial_magnitude_comparator_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic diff_seen,
  output logic set_lt,
  output logic set_gt
);

  // A difference is only reported if no more significant bit already differed
  always_comb begin
    set_lt = ~diff_seen & ~a_bit &  b_bit;
    set_gt = ~diff_seen &  a_bit & ~b_bit;
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock.
// Latency: WIDTH edges from accept to out_valid (fewer with EARLY_EXIT on a difference).
// Backpressure: in_ready low while busy; in_valid during COMPARE/DONE is ignored.
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [CW-1:0]    count;
  cmp_flags_t       flags;

  logic diff_seen;
  logic set_lt;
  logic set_gt;
  logic found_now;
  logic last_bit;

  assign diff_seen = flags.lt | flags.gt;
  assign found_now = set_lt | set_gt;
  assign last_bit  = (count == '0);

  // The cell only ever looks at the current MSB of each shift register
  serial_magnitude_comparator_bit_cell u_bit_cell (
    .a_bit     (shift_a[WIDTH-1]),
    .b_bit     (shift_b[WIDTH-1]),
    .diff_seen (diff_seen),
    .set_lt    (set_lt),
    .set_gt    (set_gt)
  );

  // Handshake and strobe decode straight from the state register
  always_comb begin
    in_ready  = (state == CMP_IDLE);
    out_valid = (state == CMP_DONE);
  end

  assign a_lt_b = flags.lt;
  assign a_gt_b = flags.gt;
  assign a_eq_b = flags.eq;

  // FSM, operand shift registers, bit counter and sticky result flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CMP_IDLE;
      shift_a <= '0;
      shift_b <= '0;
      count   <= '0;
      flags   <= RES_NONE;
    end else begin
      case (state)
        CMP_IDLE: begin
          if (in_valid) begin
            shift_a <= a;
            shift_b <= b;
            count   <= CW'(WIDTH - 1);
            flags   <= RES_NONE;
            state   <= CMP_COMPARE;
          end
        end
        CMP_COMPARE: begin
          shift_a <= shift_a << 1;
          shift_b <= shift_b << 1;
          count   <= count - CW'(1);
          if (set_lt) flags.lt <= 1'b1;
          if (set_gt) flags.gt <= 1'b1;
          // Equality is only known once bit 0 is examined without any difference
          if (last_bit && !diff_seen && !found_now) flags.eq <= 1'b1;
          if ((EARLY_EXIT && found_now) || last_bit) state <= CMP_DONE;
        end
        CMP_DONE: begin
          state <= CMP_IDLE;
        end
        default: begin
          state <= CMP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic rdy0, ov0, lt0, gt0, eq0;
  logic rdy1, ov1, lt1, gt1, eq1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .out_valid(ov0), .a_lt_b(lt0), .a_gt_b(gt0), .a_eq_b(eq0)
  );

  serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .out_valid(ov1), .a_lt_b(lt1), .a_gt_b(gt1), .a_eq_b(eq1)
  );

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [2:0]   flags;  // {lt, gt, eq}
    int           lat_full;
    int           lat_early;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: plain unsigned arithmetic
  function automatic logic [2:0] model_flags(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x < y) return 3'b100;
    if (x > y) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit early);
    int d;
    d = int'(x ^ y);
    if (!early || d == 0) return W;
    for (int i = W - 1; i >= 0; i--)
      if (d >= (1 << i)) return W - i;
    return W;
  endfunction

  // Accept one operand pair on both DUTs and watch them until both are idle again
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input bit busy_pulse,
                        output int l0, output int l1, output int s0, output int s1,
                        output int r0, output int r1,
                        output logic [2:0] f0, output logic [2:0] f1,
                        output logic [2:0] h0, output logic [2:0] h1);
    l0 = -1; l1 = -1; s0 = 0; s1 = 0; r0 = -1; r1 = -1; f0 = 3'b000; f1 = 3'b000;
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (ov0) begin s0++; l0 = k; f0 = {lt0, gt0, eq0}; end
      if (ov1) begin s1++; l1 = k; f1 = {lt1, gt1, eq1}; end
      if (l0 > 0 && k == l0 + 1) r0 = int'(rdy0);
      if (l1 > 0 && k == l1 + 1) r1 = int'(rdy1);
      if (busy_pulse && k == 2) begin a = 8'd255; b = 8'd0; in_valid = 1'b1; end
      if (busy_pulse && k == 3) in_valid = 1'b0;
    end
    h0 = {lt0, gt0, eq0};
    h1 = {lt1, gt1, eq1};
  endtask

  task automatic do_vec(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [2:0] ef, input int el0, input int el1, input bit busy);
    int l0, l1, s0, s1, r0, r1;
    logic [2:0] f0, f1, h0, h1;
    run_op(va, vb, busy, l0, l1, s0, s1, r0, r1, f0, f1, h0, h1);
    check({tag, " flags_full"},  int'(f0), int'(ef));
    check({tag, " flags_early"}, int'(f1), int'(ef));
    check({tag, " lat_full"},    l0, el0);
    check({tag, " lat_early"},   l1, el1);
    check({tag, " strobes_full"},  s0, 1);
    check({tag, " strobes_early"}, s1, 1);
    check({tag, " ready_after_full"},  r0, 1);
    check({tag, " ready_after_early"}, r1, 1);
    check({tag, " hold_full"},  int'(h0), int'(ef));
    check({tag, " hold_early"}, int'(h1), int'(ef));
  endtask

  initial begin
    vec_t vecs[8];
    int   s0, s1;
    logic [W-1:0] ra, rb;

    vecs[0] = '{8'd10,   8'd12,   3'b100, 8, 6};
    vecs[1] = '{8'd9,    8'd3,    3'b010, 8, 5};
    vecs[2] = '{8'd7,    8'd7,    3'b001, 8, 8};
    vecs[3] = '{8'h80,   8'h7F,   3'b010, 8, 1};
    vecs[4] = '{8'h21,   8'h2A,   3'b100, 8, 5};
    vecs[5] = '{8'h00,   8'h00,   3'b001, 8, 8};
    vecs[6] = '{8'hFF,   8'hFE,   3'b010, 8, 8};
    vecs[7] = '{8'h00,   8'h01,   3'b100, 8, 8};

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;

    // Reset held for two edges
    repeat (2) @(negedge clk);
    check("reset ready_full",  int'(rdy0), 1);
    check("reset ready_early", int'(rdy1), 1);
    check("reset ov_full",     int'(ov0), 0);
    check("reset ov_early",    int'(ov1), 0);
    check("reset flags_full",  int'({lt0, gt0, eq0}), 0);
    check("reset flags_early", int'({lt1, gt1, eq1}), 0);
    reset = 1'b0;

    // Directed table
    foreach (vecs[i])
      do_vec($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].flags,
             vecs[i].lat_full, vecs[i].lat_early, 1'b0);

    // Busy-time in_valid with different operands must be ignored
    do_vec("busy", 8'd21, 8'd42, 3'b100, 8, 3, 1'b1);

    // Reset three edges after accepting a=1, b=200
    @(negedge clk);
    a = 8'd1; b = 8'd200; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    s0 = 0; s1 = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (ov0) s0++;
      if (ov1) s1++;
    end
    reset = 1'b1;
    @(negedge clk);
    if (ov0) s0++;
    check("abort ov_at_reset_full", int'(ov0), 0);
    check("abort flags_full",  int'({lt0, gt0, eq0}), 0);
    check("abort flags_early", int'({lt1, gt1, eq1}), 0);
    check("abort ready_full",  int'(rdy0), 1);
    reset = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (ov0) s0++;
    end
    check("abort strobes_full",  s0, 0);
    check("abort strobes_early", s1, 1);
    check("abort idle_flags_full", int'({lt0, gt0, eq0}), 0);

    // First operands after the abort
    do_vec("post_abort", 8'd200, 8'd1, 3'b010, 8, 1, 1'b0);

    // reset and in_valid on the same edge: operands dropped
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd9;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    s0 = 0; s1 = 0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (ov0) s0++;
      if (ov1) s1++;
    end
    check("rst_vs_valid strobes_full",  s0, 0);
    check("rst_vs_valid strobes_early", s1, 0);
    check("rst_vs_valid ready_full",    int'(rdy0), 1);
    check("rst_vs_valid flags_early",   int'({lt1, gt1, eq1}), 0);

    // Randomized pairs against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rb = ra;
      do_vec($sformatf("rnd%0d", n), ra, rb, model_flags(ra, rb),
             model_lat(ra, rb, 1'b0), model_lat(ra, rb, 1'b1), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
